// File: rtl/qkv_seq_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : qkv_seq_ctrl_if
// Brief    : Token stream, engine handshake and row-drain bundle for qkv_seq_ctrl.
// Revision : 1.0  initial release
// =============================================================================
interface qkv_seq_ctrl_if #(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int SEQ_LEN = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [N-1:0][WIDTH-1:0]        in_x;

    logic                           eng_start;
    logic [N-1:0][WIDTH-1:0]        eng_x;
    logic                           eng_done;
    logic [N-1:0][WIDTH-1:0]        eng_q;
    logic [N-1:0][WIDTH-1:0]        eng_k;
    logic [N-1:0][WIDTH-1:0]        eng_v;

    logic                           out_valid;
    logic                           out_ready;
    logic [N-1:0][WIDTH-1:0]        out_q;
    logic [N-1:0][WIDTH-1:0]        out_k;
    logic [N-1:0][WIDTH-1:0]        out_v;
    logic [$clog2(SEQ_LEN)-1:0]     out_idx;
    logic                           out_last;

    logic                           err;
    logic                           err_clr;

    // Controller side
    modport master (
        input  in_valid, in_x,
        input  eng_done, eng_q, eng_k, eng_v,
        input  out_ready, err_clr,
        output in_ready, eng_start, eng_x,
        output out_valid, out_q, out_k, out_v, out_idx, out_last, err
    );

    // Environment side (token source, engine, attention stage)
    modport slave (
        output in_valid, in_x,
        output eng_done, eng_q, eng_k, eng_v,
        output out_ready, err_clr,
        input  in_ready, eng_start, eng_x,
        input  out_valid, out_q, out_k, out_v, out_idx, out_last, err
    );
endinterface
`default_nettype wire

// File: rtl/qkv_seq_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : qkv_seq_ctrl
// Brief    : Issues one QKV engine start per input token, buffers results, drains rows.
// Revision : 1.0  initial release
// =============================================================================
module qkv_seq_ctrl #(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int SEQ_LEN = 4,
    parameter int TIMEOUT = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    qkv_seq_ctrl_if.master     bus
);
    localparam int c_RDW = $clog2(SEQ_LEN);
    localparam int c_WRW = $clog2(SEQ_LEN + 1);
    localparam int c_TW  = $clog2(TIMEOUT);

    localparam logic [c_WRW-1:0] c_WR_FULL = c_WRW'(SEQ_LEN);
    localparam logic [c_RDW-1:0] c_RD_LAST = c_RDW'(SEQ_LEN - 1);
    localparam logic [c_TW-1:0]  c_T_LAST  = c_TW'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_GAP   = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;
    localparam logic [2:0] c_ST_ERROR = 3'd5;

    typedef logic [N-1:0][WIDTH-1:0] vec_t;

    logic [2:0]       state_q,   state_d;
    logic [c_WRW-1:0] wr_idx_q,  wr_idx_d;
    logic [c_RDW-1:0] rd_idx_q,  rd_idx_d;
    logic [c_TW-1:0]  timer_q,   timer_d;
    vec_t             x_q,       x_d;
    logic             capture;

    vec_t             qbuf_q [SEQ_LEN];
    vec_t             kbuf_q [SEQ_LEN];
    vec_t             vbuf_q [SEQ_LEN];

    logic             in_ready_q,  in_ready_d;
    logic             eng_start_q, eng_start_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q,  out_last_d;
    logic             err_q,       err_d;
    logic [c_RDW-1:0] out_idx_q,   out_idx_d;
    vec_t             out_q_q,     out_q_d;
    vec_t             out_k_q,     out_k_d;
    vec_t             out_v_q,     out_v_d;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            timer_q     <= '0;
            x_q         <= '0;
            in_ready_q  <= 1'b0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            out_idx_q   <= '0;
            out_q_q     <= '0;
            out_k_q     <= '0;
            out_v_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            timer_q     <= timer_d;
            x_q         <= x_d;
            in_ready_q  <= in_ready_d;
            eng_start_q <= eng_start_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            out_idx_q   <= out_idx_d;
            out_q_q     <= out_q_d;
            out_k_q     <= out_k_d;
            out_v_q     <= out_v_d;
        end
    end

    // Row buffers: results are stored bit-exact, one row per captured token
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < SEQ_LEN; r++) begin
                qbuf_q[r] <= '0;
                kbuf_q[r] <= '0;
                vbuf_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < SEQ_LEN; r++) begin
                if (capture && (wr_idx_q == c_WRW'(r))) begin
                    qbuf_q[r] <= bus.eng_q;
                    kbuf_q[r] <= bus.eng_k;
                    vbuf_q[r] <= bus.eng_v;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        timer_d  = timer_q;
        x_d      = x_q;
        capture  = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x_d     = bus.in_x;
                    state_d = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                timer_d = '0;
                state_d = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A done arriving on the last allowed cycle still counts
                if (bus.eng_done) begin
                    capture  = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    state_d  = c_ST_GAP;
                end else if (timer_q == c_T_LAST) begin
                    state_d = c_ST_ERROR;
                end
            end
            c_ST_GAP: begin
                if (wr_idx_q == c_WR_FULL) begin
                    rd_idx_d = '0;
                    state_d  = c_ST_DRAIN;
                end else begin
                    state_d = c_ST_IDLE;
                end
            end
            c_ST_DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (rd_idx_q == c_RD_LAST) begin
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        state_d  = c_ST_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            c_ST_ERROR: begin
                if (bus.err_clr) begin
                    wr_idx_d = '0;
                    timer_d  = '0;
                    state_d  = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: registered outputs follow the state being entered
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready_d  = (state_d == c_ST_IDLE);
        eng_start_d = (state_d == c_ST_ISSUE);
        out_valid_d = (state_d == c_ST_DRAIN);
        err_d       = (state_d == c_ST_ERROR);
        out_last_d  = 1'b0;
        out_idx_d   = '0;
        out_q_d     = '0;
        out_k_d     = '0;
        out_v_d     = '0;
        // While stalled rd_idx_d is unchanged, so the presented row holds
        if (state_d == c_ST_DRAIN) begin
            out_idx_d  = rd_idx_d;
            out_last_d = (rd_idx_d == c_RD_LAST);
            out_q_d    = qbuf_q[rd_idx_d];
            out_k_d    = kbuf_q[rd_idx_d];
            out_v_d    = vbuf_q[rd_idx_d];
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_x     = x_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_q     = out_q_q;
    assign bus.out_k     = out_k_q;
    assign bus.out_v     = out_v_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;

endmodule
`default_nettype wire
